// File: rtl/sipo_loader.sv
// sipo_loader: serial-in parallel-out word assembler that loads a downstream register
module sipo_loader #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         bit_in,
   input  logic         bit_valid,
   output logic [W-1:0] word_out,
   output logic         load,
   output logic         busy,
   output logic         frame_err
);
   localparam int CW = $clog2(W);
   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
   state_t state, state_n;
   logic [W-1:0] shreg, shreg_n, word_n, shifted;
   logic [CW-1:0] count, count_n;
   logic load_n, ferr_n, last;
   assign shifted = {shreg[W-2:0], bit_in};
   assign last = count == CW'(W - 1);
   // state and registered outputs; reset forces everything idle and clear
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         shreg     <= '0;
         count     <= '0;
         word_out  <= '0;
         load      <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         count     <= count_n;
         word_out  <= word_n;
         load      <= load_n;
         busy      <= state_n != IDLE;
         frame_err <= ferr_n;
      end
   end
   // next-state logic; start beats bit_valid in SHIFT, and word_out updates only on LOAD entry
   always_comb begin
      state_n = state;
      shreg_n = shreg;
      count_n = count;
      word_n  = word_out;
      load_n  = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         IDLE: begin
            state_n = start ? SHIFT : IDLE;
            count_n = '0;
            shreg_n = start ? '0 : shreg;
         end
         SHIFT: begin
            if (start) begin
               count_n = '0;
               shreg_n = '0;
               ferr_n  = count != '0;
            end else if (bit_valid) begin
               shreg_n = shifted;
               count_n = last ? '0 : count + CW'(1);
               state_n = last ? LOAD : SHIFT;
               word_n  = last ? shifted : word_out;
               load_n  = last;
            end
         end
         LOAD: begin
            state_n = start ? SHIFT : IDLE;
            count_n = '0;
            shreg_n = '0;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_sipo_loader.sv
// tb_sipo_loader: directed self-checking bench for sipo_loader with W = 5
module tb_sipo_loader;
   localparam int W = 5;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic bit_in = 1'b0;
   logic bit_valid = 1'b0;
   logic [W-1:0] word_out;
   logic load, busy, frame_err;
   int n_chk = 0;
   int n_fail = 0;
   int load_cnt = 0;
   int ferr_cnt = 0;
   sipo_loader #(.W(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .bit_in(bit_in),
      .bit_valid(bit_valid),
      .word_out(word_out),
      .load(load),
      .busy(busy),
      .frame_err(frame_err)
   );
   always #5 clk = ~clk;
   // pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (load) load_cnt++;
      if (frame_err) ferr_cnt++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic s, input logic v, input logic b);
      start = s;
      bit_valid = v;
      bit_in = b;
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) begin
         step(1'b0, 1'b1, w[i]);
         if (i > 0) chk("no_early_load", 32'(load), 0);
      end
   endtask
   task automatic clr_cnt();
      load_cnt = 0;
      ferr_cnt = 0;
   endtask
   initial begin
      logic [W-1:0] f1, f2, f3;
      f1 = 5'b11001;
      f2 = 5'b00110;
      f3 = 5'b11111;
      rst = 1'b0;
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      chk("rst_word", 32'(word_out), 0);
      chk("rst_load", 32'(load), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ferr", 32'(frame_err), 0);
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("idle_busy", 32'(busy), 0);
      // basic frame, back-to-back bits
      clr_cnt();
      step(1'b1, 1'b0, 1'b0);
      chk("start_busy", 32'(busy), 1);
      send(f1);
      chk("b2b_load", 32'(load), 1);
      chk("b2b_word", 32'(word_out), 32'(f1));
      chk("b2b_busy_load", 32'(busy), 1);
      step(1'b0, 1'b0, 1'b0);
      chk("b2b_load_off", 32'(load), 0);
      chk("b2b_busy_off", 32'(busy), 0);
      chk("b2b_word_hold", 32'(word_out), 32'(f1));
      chk("b2b_loads", 32'(load_cnt), 1);
      // silent restart at count 0, then aborted frame with start beating bit_valid
      clr_cnt();
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("restart0_ferr", 32'(frame_err), 0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      chk("partial_word_hold", 32'(word_out), 32'(f1));
      step(1'b1, 1'b1, 1'b1);
      chk("abort_ferr", 32'(frame_err), 1);
      chk("abort_busy", 32'(busy), 1);
      chk("abort_load", 32'(load), 0);
      send(f3);
      chk("abort_ferr_pulse", 32'(frame_err), 0);
      chk("abort_word", 32'(word_out), 32'(f3));
      chk("abort_loadbit", 32'(load), 1);
      step(1'b0, 1'b0, 1'b0);
      chk("abort_loads", 32'(load_cnt), 1);
      chk("abort_ferrs", 32'(ferr_cnt), 1);
      // frame with idle gaps between bits
      clr_cnt();
      step(1'b1, 1'b0, 1'b0);
      for (int i = W - 1; i >= 0; i--) begin
         for (int g = 0; g < (i % 3) + 1; g++) begin
            step(1'b0, 1'b0, ~f1[i]);
            chk("gap_busy", 32'(busy), 1);
            chk("gap_word_hold", 32'(word_out), 32'(f3));
         end
         step(1'b0, 1'b1, f1[i]);
      end
      chk("gap_word", 32'(word_out), 32'(f1));
      step(1'b0, 1'b0, 1'b0);
      chk("gap_loads", 32'(load_cnt), 1);
      chk("gap_busy_off", 32'(busy), 0);
      // start during LOAD chains straight into the next frame
      clr_cnt();
      step(1'b1, 1'b0, 1'b0);
      send(f3);
      chk("chain_word1", 32'(word_out), 32'(f3));
      step(1'b1, 1'b1, 1'b0);
      chk("chain_busy", 32'(busy), 1);
      chk("chain_load_off", 32'(load), 0);
      send(f2);
      chk("chain_word2", 32'(word_out), 32'(f2));
      chk("chain_busy2", 32'(busy), 1);
      step(1'b0, 1'b0, 1'b0);
      chk("chain_loads", 32'(load_cnt), 2);
      chk("chain_ferrs", 32'(ferr_cnt), 0);
      // reset mid-frame, then stray bits without start, then a fresh frame
      clr_cnt();
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      rst = 1'b0;
      step(1'b0, 1'b1, 1'b1);
      chk("mid_rst_word", 32'(word_out), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      step(1'b0, 1'b1, 1'b1);
      rst = 1'b1;
      send(f3);
      chk("post_rst_nostart_load", 32'(load), 0);
      chk("post_rst_nostart_busy", 32'(busy), 0);
      step(1'b1, 1'b0, 1'b0);
      send(f3);
      chk("post_rst_word", 32'(word_out), 32'(f3));
      step(1'b0, 1'b0, 1'b0);
      chk("post_rst_loads", 32'(load_cnt), 1);
      chk("post_rst_ferrs", 32'(ferr_cnt), 0);
      // reset on the completing edge suppresses the load
      clr_cnt();
      step(1'b1, 1'b0, 1'b0);
      for (int i = W - 1; i > 0; i--) step(1'b0, 1'b1, f1[i]);
      rst = 1'b0;
      step(1'b0, 1'b1, f1[0]);
      chk("rst_complete_load", 32'(load), 0);
      chk("rst_complete_word", 32'(word_out), 0);
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("rst_complete_loads", 32'(load_cnt), 0);
      // bit_valid toggling while idle has no effect
      clr_cnt();
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'(i % 2), 1'(i / 2));
         chk("idle_quiet", {29'd0, busy, load, frame_err}, 0);
      end
      chk("idle_word", 32'(word_out), 0);
      chk("idle_pulses", 32'(load_cnt + ferr_cnt), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
